// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Byte-stream valid/ready channel feeding the program loader.
//   master : stream source (drives in_valid / in_data, observes in_ready)
//   slave  : loader        (observes in_valid / in_data, drives in_ready)
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Accepts a framed byte stream {N lo, N hi, 4*N little-endian word bytes,
//   checksum} and writes each assembled word into instruction memory. The
//   CPU is held in reset from the start of a load until a frame completes
//   with a matching checksum; it stays held after any error.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   load_req   start a frame (honoured in IDLE and ERR only)
//   s          byte stream slave (in_valid, in_data, in_ready)
//   imem_we    one-cycle write strobe per assembled word
//   imem_addr  byte address of the write (BASE_ADDR + 4*k)
//   imem_wd    assembled instruction word
//   cpu_hold   high keeps the datapath in reset
//   busy       frame in progress (LEN0..CSUM)
//   done       one-cycle pulse on successful completion
//   error      high while in ERR
//   err_code   01 length too large, 10 checksum mismatch
module imem_loader #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 256,
    parameter logic [WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_req,
    imem_loader_if.slave     s,
    output logic             imem_we,
    output logic [WIDTH-1:0] imem_addr,
    output logic [WIDTH-1:0] imem_wd,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code
);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, ERR} state_t;

    state_t           state_q;
    logic [1:0]       lane_q;
    logic [15:0]      k_q;
    logic [15:0]      len_q;
    logic [7:0]       sum_q;
    logic [23:0]      word_q;
    logic             imem_we_q;
    logic [WIDTH-1:0] imem_addr_q;
    logic [WIDTH-1:0] imem_wd_q;
    logic             cpu_hold_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic [1:0]       err_code_q;

    logic             accept;
    logic [7:0]       sum_d;
    logic [15:0]      len_d;

    assign s.in_ready = (state_q == LEN0) || (state_q == LEN1) ||
                        (state_q == DATA) || (state_q == CSUM);
    assign accept     = s.in_valid & s.in_ready;
    assign sum_d      = sum_q + s.in_data;
    assign len_d      = {s.in_data, len_q[7:0]};

    assign imem_we   = imem_we_q;
    assign imem_addr = imem_addr_q;
    assign imem_wd   = imem_wd_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            k_q         <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            word_q      <= '0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= BASE_ADDR;
            imem_wd_q   <= '0;
            cpu_hold_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            imem_we_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE, ERR: begin
                    if (load_req) begin
                        state_q    <= LEN0;
                        k_q        <= '0;
                        sum_q      <= '0;
                        lane_q     <= '0;
                        cpu_hold_q <= 1'b1;
                        busy_q     <= 1'b1;
                        error_q    <= 1'b0;
                        err_code_q <= 2'b00;
                    end
                end
                LEN0: begin
                    if (accept) begin
                        len_q   <= {8'd0, s.in_data};
                        sum_q   <= sum_d;
                        state_q <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        len_q <= len_d;
                        sum_q <= sum_d;
                        if ({16'd0, len_d} > DEPTH) begin
                            state_q    <= ERR;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= 2'b01;
                        end else if (len_d == 16'd0) begin
                            state_q <= CSUM;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        sum_q  <= sum_d;
                        lane_q <= lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            // Lanes 0..2 sit in word_q (lane 0 lowest); this byte is the top.
                            imem_we_q   <= 1'b1;
                            imem_addr_q <= BASE_ADDR + WIDTH'({k_q, 2'b00});
                            imem_wd_q   <= WIDTH'({s.in_data, word_q});
                            k_q         <= k_q + 16'd1;
                            if (k_q == len_q - 16'd1) begin
                                state_q <= CSUM;
                            end
                        end else begin
                            word_q <= {s.in_data, word_q[23:8]};
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        busy_q <= 1'b0;
                        if (s.in_data == sum_q) begin
                            state_q    <= IDLE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q    <= ERR;
                            error_q    <= 1'b1;
                            err_code_q <= 2'b10;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_req;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    imem_loader_if sif();

    imem_loader #(.WIDTH(32), .DEPTH(256), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .load_req (load_req),
        .s        (sif),
        .imem_we  (imem_we),
        .imem_addr(imem_addr),
        .imem_wd  (imem_wd),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          nb;
        logic [7:0]  b [12];
        int          gap;
        int          nwr;
        logic [31:0] w0;
        logic [31:0] w1;
        int          res;   // 0 done, 1 length error, 2 checksum error
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  frm[$];
    wr_t         got_wr[$];
    wr_t         exp_wr[$];
    int          exp_res;
    int          done_cnt = 0;
    int          wb;
    int          db;
    vec_t        tbl [5];

    // Write/done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we) got_wr.push_back({imem_addr, imem_wd});
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   t;
        repeat (gap) tick();
        sif.in_valid = 1'b1;
        sif.in_data  = b;
        rdy = 1'b0;
        t   = 0;
        while (!rdy && t < 40) begin
            @(negedge clk);
            rdy = sif.in_ready;
            tick();
            t++;
        end
        sif.in_valid = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte %h not accepted within 40 cycles", b);
        end
    endtask

    // Reference: decode the frame in frm from the framing rules.
    task automatic build_expect();
        int         n;
        logic [7:0] s;
        exp_wr.delete();
        n = int'({frm[1], frm[0]});
        if (n > 256) begin
            exp_res = 1;
            return;
        end
        s = 8'd0;
        for (int i = 0; i < 2 + 4 * n; i++) s = s + frm[i];
        for (int w = 0; w < n; w++) begin
            int k;
            k = 2 + 4 * w;
            exp_wr.push_back({BASE + 32'(4 * w), {frm[k+3], frm[k+2], frm[k+1], frm[k]}});
        end
        exp_res = (frm[2 + 4 * n] == s) ? 0 : 2;
    endtask

    task automatic run_frame(input int gapmax);
        wb = got_wr.size();
        db = done_cnt;
        pulse_load();
        chk("start_error_clear", {31'd0, error}, 32'd0);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_hold", {31'd0, cpu_hold}, 32'd1);
        for (int i = 0; i < frm.size(); i++)
            send_byte(frm[i], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
        repeat (3) tick();
    endtask

    task automatic verify(input string tag);
        chk({tag, "_nwr"}, 32'(got_wr.size() - wb), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && (wb + i) < got_wr.size(); i++) begin
            chk({tag, "_addr"}, got_wr[wb + i].addr, exp_wr[i].addr);
            chk({tag, "_data"}, got_wr[wb + i].data, exp_wr[i].data);
        end
        chk({tag, "_done"}, 32'(done_cnt - db), (exp_res == 0) ? 32'd1 : 32'd0);
        chk({tag, "_error"}, {31'd0, error}, (exp_res != 0) ? 32'd1 : 32'd0);
        chk({tag, "_code"}, {30'd0, err_code}, (exp_res == 1) ? 32'd1 : (exp_res == 2) ? 32'd2 : 32'd0);
        chk({tag, "_hold"}, {31'd0, cpu_hold}, (exp_res != 0) ? 32'd1 : 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ready"}, {31'd0, sif.in_ready}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
        chk({tag, "_addr"}, imem_addr, BASE);
        chk({tag, "_wd"}, imem_wd, 32'd0);
        chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_code"}, {30'd0, err_code}, 32'd0);
        chk({tag, "_ready"}, {31'd0, sif.in_ready}, 32'd0);
    endtask

    task automatic load_nominal();
        frm.delete();
        // Checksum 0xE2 = sum of the ten preceding bytes mod 256.
        frm = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hE2};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        load_req     = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_data  = 8'h00;

        tbl[0] = '{nb: 11, b: '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hE2, 8'h00},
                   gap: 0, nwr: 2, w0: 32'h0010_0513, w1: 32'h0020_0593, res: 0};
        tbl[1] = '{nb: 3, b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   gap: 0, nwr: 0, w0: 32'h0, w1: 32'h0, res: 0};
        tbl[2] = '{nb: 11, b: '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'h33, 8'h00},
                   gap: 0, nwr: 2, w0: 32'h0010_0513, w1: 32'h0020_0593, res: 2};
        tbl[3] = '{nb: 2, b: '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   gap: 0, nwr: 0, w0: 32'h0, w1: 32'h0, res: 1};
        tbl[4] = '{nb: 11, b: '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hE2, 8'h00},
                   gap: 5, nwr: 2, w0: 32'h0010_0513, w1: 32'h0020_0593, res: 0};

        repeat (2) tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Table-driven frames.
        for (int v = 0; v < 5; v++) begin
            frm.delete();
            for (int i = 0; i < tbl[v].nb; i++) frm.push_back(tbl[v].b[i]);
            exp_wr.delete();
            if (tbl[v].nwr > 0) exp_wr.push_back({BASE, tbl[v].w0});
            if (tbl[v].nwr > 1) exp_wr.push_back({BASE + 32'd4, tbl[v].w1});
            exp_res = tbl[v].res;
            run_frame(tbl[v].gap);
            verify($sformatf("vec%0d", v));
        end

        // Nominal frame with cycle-exact write/done timing and ignored load_req.
        load_nominal();
        wb = got_wr.size();
        db = done_cnt;
        pulse_load();
        for (int i = 0; i < 11; i++) begin
            send_byte(frm[i], 0);
            if (i == 5) begin
                chk("t_we0", {31'd0, imem_we}, 32'd1);
                chk("t_addr0", imem_addr, BASE);
                chk("t_wd0", imem_wd, 32'h0010_0513);
                tick();
                chk("t_we0_low", {31'd0, imem_we}, 32'd0);
            end
            if (i == 6) begin
                pulse_load();
                chk("t_ldreq_busy", {31'd0, busy}, 32'd1);
                chk("t_ldreq_ready", {31'd0, sif.in_ready}, 32'd1);
            end
            if (i == 9) begin
                chk("t_we1", {31'd0, imem_we}, 32'd1);
                chk("t_addr1", imem_addr, BASE + 32'd4);
                chk("t_wd1", imem_wd, 32'h0020_0593);
            end
        end
        chk("t_done_hi", {31'd0, done}, 32'd1);
        chk("t_hold_lo", {31'd0, cpu_hold}, 32'd0);
        tick();
        chk("t_done_lo", {31'd0, done}, 32'd0);
        chk("t_nwr", 32'(got_wr.size() - wb), 32'd2);
        chk("t_done_cnt", 32'(done_cnt - db), 32'd1);

        // Overflow: stream stalls after the second length byte.
        wb = got_wr.size();
        pulse_load();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk("ovf_error", {31'd0, error}, 32'd1);
        chk("ovf_code", {30'd0, err_code}, 32'd1);
        begin
            int rdy_seen;
            rdy_seen = 0;
            sif.in_valid = 1'b1;
            sif.in_data  = 8'hAA;
            repeat (4) begin
                @(negedge clk);
                if (sif.in_ready) rdy_seen++;
                tick();
            end
            sif.in_valid = 1'b0;
            chk("ovf_ready", 32'(rdy_seen), 32'd0);
        end
        chk("ovf_nwr", 32'(got_wr.size() - wb), 32'd0);
        chk("ovf_hold", {31'd0, cpu_hold}, 32'd1);

        // Reset mid-frame, then a clean reload.
        load_nominal();
        pulse_load();
        for (int i = 0; i < 6; i++) send_byte(frm[i], 0);
        rst_n = 1'b0;
        #2;
        check_reset_vals("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        build_expect();
        run_frame(2);
        verify("after_rst");

        // Largest legal frame.
        frm.delete();
        frm.push_back(8'h00);
        frm.push_back(8'h01);
        for (int i = 0; i < 1024; i++) frm.push_back(8'($urandom));
        begin
            logic [7:0] s;
            s = 8'd0;
            foreach (frm[i]) s = s + frm[i];
            frm.push_back(s);
        end
        build_expect();
        run_frame(0);
        verify("depth");

        // Random frames against the reference.
        for (int r = 0; r < 25; r++) begin
            int         n;
            logic [7:0] s;
            frm.delete();
            if ($urandom_range(9, 0) == 0) n = int'($urandom_range(400, 257));
            else n = int'($urandom_range(5, 0));
            frm.push_back(n[7:0]);
            frm.push_back(n[15:8]);
            if (n <= 256) begin
                for (int i = 0; i < 4 * n; i++) frm.push_back(8'($urandom));
                s = 8'd0;
                foreach (frm[i]) s = s + frm[i];
                if ($urandom_range(3, 0) == 0) s = s + 8'($urandom_range(255, 1));
                frm.push_back(s);
            end
            build_expect();
            run_frame(5);
            verify($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
